pingpong_sram_buf: RTL and testbench
====================================

Name: pingpong_sram_buf

Overview:
- Parametrised N-bank ping-pong activation buffer between layer engines in the binarynet datapath.
- Generalises the fixed two-bank buffer with explicit chip-select, output-enable and write-enable pins.
- The producer fills one bank while the consumer drains previously completed banks.
- Bank rotation, full/empty tracking, a registered synchronous read port and protocol-error flagging are handled internally, so engines no longer drive per-bank cs/oe/we.

Parameters:
DATA_WIDTH, 16, word width of every bank
ADDR_WIDTH, 10, word address width; each bank holds 2**ADDR_WIDTH words
NUM_BANKS, 2, bank count; legal range 2..8
BANK_W, $clog2(NUM_BANKS), derived; width of bank index outputs

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
wr_en  input  1  write wr_data to wr_addr of current write bank
wr_addr  input  ADDR_WIDTH  write word address
wr_data  input  DATA_WIDTH  write data
wr_done  input  1  producer finished current bank; commit it
wr_ready  output  1  a bank is available for writing
wr_bank  output  BANK_W  index of current write bank
rd_en  input  1  read rd_addr of current read bank
rd_addr  input  ADDR_WIDTH  read word address
rd_done  input  1  consumer finished current bank; release it
rd_avail  output  1  at least one committed bank is readable
rd_bank  output  BANK_W  index of current read bank
rd_data  output  DATA_WIDTH  registered read data
rd_data_valid  output  1  rd_data holds data for the rd_en of the previous cycle
full_cnt  output  BANK_W+1  number of committed, unreleased banks
err  output  1  sticky protocol-error flag

Behaviour:
- Reset (synchronous, active-high) clears wr_bank, rd_bank, full_cnt, rd_data, rd_data_valid and err to 0. Bank contents are not cleared.
- Reset has priority over every other input, including mid-fill and mid-drain. All banks become logically empty, and any read pending in that cycle produces no rd_data_valid.
- Combinational outputs:
  - wr_ready = (full_cnt < NUM_BANKS)
  - rd_avail = (full_cnt != 0)
- Write: when wr_en & wr_ready, mem[wr_bank][wr_addr] <= wr_data at the clock edge.
- wr_en while !wr_ready: the write is dropped, memory is unchanged, and err <= 1.
- Commit: when wr_done & wr_ready, wr_bank advances (wr_bank == NUM_BANKS-1 wraps to 0) and full_cnt increments.
  - A wr_en in the same cycle writes the old bank.
  - wr_done while !wr_ready is ignored and sets err.
- Read: when rd_en & rd_avail, rd_data <= mem[rd_bank][rd_addr] and rd_data_valid <= 1.
  - Latency is exactly 1 cycle.
  - rd_data_valid is otherwise 0 next cycle; rd_data holds its last value when not reading.
- rd_en while !rd_avail: no read occurs, rd_data_valid <= 0, and err <= 1.
- Release: when rd_done & rd_avail, rd_bank advances with wrap and full_cnt decrements.
  - A rd_en in the same cycle reads the old bank; its data still returns next cycle with valid = 1.
  - rd_done while !rd_avail is ignored and sets err.
- Simultaneous legal wr_done and rd_done: both pointers advance and full_cnt is unchanged.
- Simultaneous bank conflict is impossible:
  - A write and a read to the same bank would need wr_bank == rd_bank.
  - That equality holds only when full_cnt == 0 (read blocked) or full_cnt == NUM_BANKS (write blocked).
- No read-during-write hazard rule is needed.
- err clears only on rst.
- Storage: one simple dual-port array per bank, with the write port and a registered read port. It must infer block RAM; no reset on the arrays.

Test Plan:
1. Reset then idle:
   - Response: wr_ready = 1, rd_avail = 0, full_cnt = 0, wr_bank = rd_bank = 0, rd_data_valid = 0, err = 0.
2. Single-bank round trip (NUM_BANKS = 2, ADDR_WIDTH = 10):
   - Stimulus: write addr k with data k^16'hA5A5 for k = 0..1023, pulse wr_done, then read addr 0..1023 back to back.
   - Response: after wr_done, full_cnt = 1, wr_bank = 1, rd_avail = 1. Each rd_data equals k^16'hA5A5 one cycle after its rd_en, with rd_data_valid = 1.
   - Then pulse rd_done: full_cnt = 0, rd_bank = 1.
3. Fill-all / overflow:
   - Stimulus: commit 2 banks without reading, then assert wr_en at addr 5 with data 16'hFFFF.
   - Response: wr_ready = 0, full_cnt = 2, err = 1. After one rd_done, bank 0 reads back its original data with no 16'hFFFF.
4. Concurrent stream:
   - Stimulus: the producer fills bank 1 while the consumer reads bank 0; wr_done and rd_done are asserted in the same cycle.
   - Response: full_cnt stays 1, wr_bank = 0, rd_bank = 1, and the bank 1 data is intact.
5. Wrap-around (NUM_BANKS = 3):
   - Stimulus: 7 commit/release cycles with data tagged by cycle number.
   - Response: bank indices follow 0,1,2,0,1,2,0 and each drained bank returns its own tag.
6. Reset mid-operation:
   - Stimulus: assert rst while full_cnt = 1 and rd_en = 1.
   - Response: next cycle full_cnt = 0, rd_data_valid = 0, err = 0, both bank indices are 0, and rd_en now sets err.

Source files
------------

// File: rtl/pingpong_sram_buf_if.sv
// Producer/consumer bus of the ping-pong activation buffer.
// The master side drives writes/reads; the slave side is the buffer itself.
interface pingpong_sram_buf_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BANKS  = 2,
  parameter int BANK_W     = $clog2(NUM_BANKS)
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_done;
  logic                  wr_ready;
  logic [BANK_W-1:0]     wr_bank;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_done;
  logic                  rd_avail;
  logic [BANK_W-1:0]     rd_bank;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic [BANK_W:0]       full_cnt;
  logic                  err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
    input  wr_ready, wr_bank, rd_avail, rd_bank, rd_data, rd_data_valid, full_cnt, err
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
    output wr_ready, wr_bank, rd_avail, rd_bank, rd_data, rd_data_valid, full_cnt, err
  );
endinterface

// File: rtl/pingpong_sram_buf.sv
// N-bank ping-pong activation buffer: producer fills one bank while the
// consumer drains committed banks; rotation, occupancy and error flag are internal.
module pingpong_sram_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BANKS  = 2,
  parameter int BANK_W     = $clog2(NUM_BANKS)
) (
  input logic clk,
  input logic rst,
  pingpong_sram_buf_if.slave bus
);
  localparam int              DEPTH = 2**ADDR_WIDTH;
  localparam logic [BANK_W:0] NB    = (BANK_W+1)'(NUM_BANKS);
  localparam logic [BANK_W-1:0] LAST = BANK_W'(NUM_BANKS-1);

  logic [BANK_W-1:0] wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, rsel_q;
  logic [BANK_W:0]   full_cnt_q, full_cnt_d;
  logic              err_q, err_d, rvld_q, rzero_q;
  logic              wr_ready, rd_avail, wr_fire, wr_commit, rd_fire, rd_rel;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rd;

  assign wr_ready  = full_cnt_q < NB;
  assign rd_avail  = full_cnt_q != '0;
  assign wr_fire   = bus.wr_en   & wr_ready & ~rst;
  assign wr_commit = bus.wr_done & wr_ready;
  assign rd_fire   = bus.rd_en   & rd_avail & ~rst;
  assign rd_rel    = bus.rd_done & rd_avail;

  always_comb begin
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    if (wr_commit) wr_bank_d = (wr_bank_q == LAST) ? '0 : wr_bank_q + 1'b1;
    if (rd_rel)    rd_bank_d = (rd_bank_q == LAST) ? '0 : rd_bank_q + 1'b1;
    full_cnt_d = full_cnt_q + {{BANK_W{1'b0}}, wr_commit} - {{BANK_W{1'b0}}, rd_rel};
    err_d      = err_q | ((bus.wr_en | bus.wr_done) & ~wr_ready)
                       | ((bus.rd_en | bus.rd_done) & ~rd_avail);
  end

  // rzero_q masks the bank read registers (which have no reset) until the first read
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      full_cnt_q <= '0;
      err_q      <= 1'b0;
      rvld_q     <= 1'b0;
      rsel_q     <= '0;
      rzero_q    <= 1'b1;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_cnt_q <= full_cnt_d;
      err_q      <= err_d;
      rvld_q     <= rd_fire;
      if (rd_fire) begin
        rsel_q  <= rd_bank_q;
        rzero_q <= 1'b0;
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if (wr_fire && wr_bank_q == BANK_W'(b)) mem[bus.wr_addr] <= bus.wr_data;
      if (rd_fire && rd_bank_q == BANK_W'(b)) rdata_q <= mem[bus.rd_addr];
    end
    assign bank_rd[b] = rdata_q;
  end

  assign bus.wr_ready      = wr_ready;
  assign bus.rd_avail      = rd_avail;
  assign bus.wr_bank       = wr_bank_q;
  assign bus.rd_bank       = rd_bank_q;
  assign bus.full_cnt      = full_cnt_q;
  assign bus.err           = err_q;
  assign bus.rd_data_valid = rvld_q;
  assign bus.rd_data       = rzero_q ? '0 : bank_rd[rsel_q];
endmodule

// File: tb/tb_pingpong_sram_buf.sv
// Scoreboard bench: a 2-bank/1K-word instance for the main scenarios and a
// 3-bank/16-word instance for pointer wrap-around.
module tb_pingpong_sram_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pingpong_sram_buf_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .NUM_BANKS(2)) if2();
  pingpong_sram_buf_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4),  .NUM_BANKS(3)) if3();

  pingpong_sram_buf #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .NUM_BANKS(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
  pingpong_sram_buf #(.DATA_WIDTH(16), .ADDR_WIDTH(4),  .NUM_BANKS(3)) u3 (.clk(clk), .rst(rst), .bus(if3));

  typedef struct { logic [15:0] d; int due; } exp_t;
  exp_t exp2[$];
  exp_t exp3[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-data scoreboards: each accepted rd_en must return exactly one cycle later.
  always @(negedge clk) if (mon_en) begin
    exp_t e;
    while (exp2.size() != 0 && exp2[0].due < cyc) begin
      e = exp2.pop_front(); checks++; errors++;
      $display("FAIL rd2_missing: data %h due cycle %0d never returned", e.d, e.due);
    end
    checks++;
    if (exp2.size() != 0 && exp2[0].due == cyc) begin
      e = exp2.pop_front();
      if (if2.rd_data_valid !== 1'b1 || if2.rd_data !== e.d) begin
        errors++;
        $display("FAIL rd2_data: got valid=%b data=%h, want valid=1 data=%h", if2.rd_data_valid, if2.rd_data, e.d);
      end
    end else if (if2.rd_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd2_unexpected_valid: got valid=%b, want 0", if2.rd_data_valid);
    end
    while (exp3.size() != 0 && exp3[0].due < cyc) begin
      e = exp3.pop_front(); checks++; errors++;
      $display("FAIL rd3_missing: data %h due cycle %0d never returned", e.d, e.due);
    end
    checks++;
    if (exp3.size() != 0 && exp3[0].due == cyc) begin
      e = exp3.pop_front();
      if (if3.rd_data_valid !== 1'b1 || if3.rd_data !== e.d) begin
        errors++;
        $display("FAIL rd3_data: got valid=%b data=%h, want valid=1 data=%h", if3.rd_data_valid, if3.rd_data, e.d);
      end
    end else if (if3.rd_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd3_unexpected_valid: got valid=%b, want 0", if3.rd_data_valid);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    if2.wr_en = 0; if2.wr_addr = '0; if2.wr_data = '0; if2.wr_done = 0;
    if2.rd_en = 0; if2.rd_addr = '0; if2.rd_done = 0;
    if3.wr_en = 0; if3.wr_addr = '0; if3.wr_data = '0; if3.wr_done = 0;
    if3.rd_en = 0; if3.rd_addr = '0; if3.rd_done = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Fill n words of the current 2-bank write bank, then commit it.
  task automatic fill2(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) begin
      if2.wr_en = 1; if2.wr_addr = 10'(k); if2.wr_data = base ^ 16'(k); step();
    end
    if2.wr_en = 0; if2.wr_done = 1; step(); if2.wr_done = 0;
  endtask

  task automatic drain2(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) begin
      if2.rd_en = 1; if2.rd_addr = 10'(k);
      exp2.push_back('{d: base ^ 16'(k), due: cyc + 1});
      step();
    end
    if2.rd_en = 0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1; step(); step(); rst = 0;
    chk("rst_wr_ready", 32'(if2.wr_ready), 1);
    chk("rst_rd_avail", 32'(if2.rd_avail), 0);
    chk("rst_full_cnt", 32'(if2.full_cnt), 0);
    chk("rst_wr_bank",  32'(if2.wr_bank),  0);
    chk("rst_rd_bank",  32'(if2.rd_bank),  0);
    chk("rst_rd_valid", 32'(if2.rd_data_valid), 0);
    chk("rst_rd_data",  32'(if2.rd_data),  0);
    chk("rst_err",      32'(if2.err),      0);
    chk("rst3_full_cnt", 32'(if3.full_cnt), 0);
    chk("rst3_err",      32'(if3.err),      0);
    mon_en = 1'b1;
  endtask

  task automatic test_round_trip();
    fill2(1024, 16'hA5A5);
    chk("rt_full_cnt", 32'(if2.full_cnt), 1);
    chk("rt_wr_bank",  32'(if2.wr_bank),  1);
    chk("rt_rd_avail", 32'(if2.rd_avail), 1);
    drain2(1024, 16'hA5A5);
    if2.rd_done = 1; step(); if2.rd_done = 0;
    chk("rt_rel_full_cnt", 32'(if2.full_cnt), 0);
    chk("rt_rel_rd_bank",  32'(if2.rd_bank),  1);
    chk("rt_err",          32'(if2.err),      0);
  endtask

  task automatic test_overflow();
    fill2(8, 16'h1000);   // bank 1
    fill2(8, 16'h2000);   // bank 0
    if2.wr_en = 1; if2.wr_addr = 10'd5; if2.wr_data = 16'hFFFF; step(); if2.wr_en = 0;
    chk("ovf_wr_ready", 32'(if2.wr_ready), 0);
    chk("ovf_full_cnt", 32'(if2.full_cnt), 2);
    chk("ovf_err",      32'(if2.err),      1);
    if2.wr_done = 1; step(); if2.wr_done = 0;
    chk("ovf_done_ignored_wr_bank", 32'(if2.wr_bank), 1);
    chk("ovf_done_ignored_cnt",     32'(if2.full_cnt), 2);
    if2.rd_done = 1; step(); if2.rd_done = 0;
    chk("ovf_rel_rd_bank",  32'(if2.rd_bank),  0);
    chk("ovf_rel_full_cnt", 32'(if2.full_cnt), 1);
    drain2(8, 16'h2000);
    if2.rd_done = 1; step(); if2.rd_done = 0;
    chk("ovf_empty_cnt", 32'(if2.full_cnt), 0);
  endtask

  task automatic test_concurrent();
    rst = 1; step(); rst = 0;
    fill2(16, 16'h3000);  // bank 0
    for (int k = 0; k < 16; k++) begin
      if2.wr_en = 1; if2.wr_addr = 10'(k); if2.wr_data = 16'h4000 ^ 16'(k);
      if2.rd_en = 1; if2.rd_addr = 10'(15 - k);
      exp2.push_back('{d: 16'h3000 ^ 16'(15 - k), due: cyc + 1});
      step();
    end
    if2.wr_en = 0; if2.rd_en = 0;
    if2.wr_done = 1; if2.rd_done = 1; step(); if2.wr_done = 0; if2.rd_done = 0;
    chk("cc_full_cnt", 32'(if2.full_cnt), 1);
    chk("cc_wr_bank",  32'(if2.wr_bank),  0);
    chk("cc_rd_bank",  32'(if2.rd_bank),  1);
    drain2(16, 16'h4000);
    chk("cc_err", 32'(if2.err), 0);
  endtask

  task automatic test_reset_mid();
    rst = 1; if2.rd_en = 1; if2.rd_addr = 10'd0; step();
    rst = 0; if2.rd_en = 0;
    chk("rm_full_cnt", 32'(if2.full_cnt), 0);
    chk("rm_rd_valid", 32'(if2.rd_data_valid), 0);
    chk("rm_err",      32'(if2.err), 0);
    chk("rm_wr_bank",  32'(if2.wr_bank), 0);
    chk("rm_rd_bank",  32'(if2.rd_bank), 0);
    if2.rd_en = 1; step(); if2.rd_en = 0;
    chk("rm_empty_rd_err",   32'(if2.err), 1);
    chk("rm_empty_rd_valid", 32'(if2.rd_data_valid), 0);
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("wrap%0d_wr_bank", c), 32'(if3.wr_bank), c % 3);
      chk($sformatf("wrap%0d_rd_bank", c), 32'(if3.rd_bank), c % 3);
      for (int k = 0; k < 4; k++) begin
        if3.wr_en = 1; if3.wr_addr = 4'(k); if3.wr_data = 16'hC000 | 16'(c << 4) | 16'(k); step();
      end
      if3.wr_en = 0; if3.wr_done = 1; step(); if3.wr_done = 0;
      for (int k = 0; k < 4; k++) begin
        if3.rd_en = 1; if3.rd_addr = 4'(k);
        exp3.push_back('{d: 16'hC000 | 16'(c << 4) | 16'(k), due: cyc + 1});
        step();
      end
      if3.rd_en = 0; if3.rd_done = 1; step(); if3.rd_done = 0;
    end
    chk("wrap_full_cnt", 32'(if3.full_cnt), 0);
    chk("wrap_err",      32'(if3.err), 0);
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_overflow();
    test_concurrent();
    test_reset_mid();
    test_wrap();
    repeat (4) step();
    chk("sb2_drained", 32'(exp2.size()), 0);
    chk("sb3_drained", 32'(exp3.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
